// File: rtl/addsub_rr_arbiter.sv
// Purpose: round-robin sequencer sharing one W-bit add/sub datapath among NREQ requesters.
// Latency: req seen in IDLE at cycle t -> gnt pulse at t+1 -> rsp_valid from t+2 (one op per 3 cycles best case).
// Backpressure: rsp_* held while rsp_ready=0; no new grant is issued until the response is taken.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req/req_a/req_b/  per-requester request, flattened operands ([i*W +: W]) and
//   req_sub           op select (1 = a-b, 0 = a+b); held until that requester's gnt
//   gnt               one-hot, single-cycle acceptance pulse
//   dp_a/dp_b/dp_sub  registered operands and subtract control to the external datapath
//   dp_sum/dp_cout    combinational result returned by the datapath
//   rsp_valid/ready   response handshake carrying rsp_id, rsp_sum, rsp_cout
//   busy              high whenever the sequencer is not IDLE
//
// Optional: define ADDSUB_ARB_OVF_EN to add rsp_ovf, the captured two's-complement
// signed-overflow flag of the operation.

module addsub_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 12,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_sub,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      dp_a,
  output logic [W-1:0]      dp_b,
  output logic              dp_sub,
  input  logic [W-1:0]      dp_sum,
  input  logic              dp_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
`ifdef ADDSUB_ARB_OVF_EN
  output logic              rsp_ovf,
`endif
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;

  logic [NREQ-1:0] mask_hi;
  logic [NREQ-1:0] pend_hi;
  logic [NREQ-1:0] search_vec;
  logic            sel_vld;
  logic [PW-1:0]   sel_idx;
  logic [NREQ-1:0] sel_oh;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic            sel_sub;

  logic            grant_en;
  logic            capture_en;
  logic            rsp_done;

  // Round-robin pick: requests at or above ptr win first; if none of those
  // are pending, wrap and take the lowest-numbered request overall.
  always_comb begin
    mask_hi = '0;
    for (int i = 0; i < NREQ; i++) begin
      mask_hi[i] = (i >= int'(ptr));
    end
    pend_hi    = req & mask_hi;
    search_vec = (|pend_hi) ? pend_hi : req;
  end

  // Lowest set bit of search_vec, with the winner's operands muxed out.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    sel_oh  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!sel_vld && search_vec[i]) begin
        sel_vld    = 1'b1;
        sel_idx    = PW'(i);
        sel_oh[i]  = 1'b1;
        sel_a      = req_a[i*W +: W];
        sel_b      = req_b[i*W +: W];
        sel_sub    = req_sub[i];
      end
    end
  end

  // Pointer moves one past the winner, wrapping at NREQ (not at 2**PW).
  always_comb begin
    if (sel_idx == PW'(NREQ - 1)) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = sel_idx + PW'(1);
    end
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    state_nxt  = state;
    grant_en   = 1'b0;
    capture_en = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          grant_en  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        capture_en = 1'b1;
        state_nxt  = RESP;
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef ADDSUB_ARB_OVF_EN
  // Signed overflow: operands (B as seen by the adder, i.e. inverted for
  // subtract) share a sign and the result's sign differs from A.
  logic ovf_calc;
  always_comb begin
    if (dp_sub) begin
      ovf_calc = (dp_a[W-1] != dp_b[W-1]) && (dp_sum[W-1] != dp_a[W-1]);
    end else begin
      ovf_calc = (dp_a[W-1] == dp_b[W-1]) && (dp_sum[W-1] != dp_a[W-1]);
    end
  end
`endif

  // Datapath drive, grant pulse and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      gnt       <= '0;
      dp_a      <= '0;
      dp_b      <= '0;
      dp_sub    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
`ifdef ADDSUB_ARB_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      // gnt is only ever high during the single ISSUE cycle.
      gnt <= '0;
      if (grant_en) begin
        gnt    <= sel_oh;
        dp_a   <= sel_a;
        dp_b   <= sel_b;
        dp_sub <= sel_sub;
        rsp_id <= IDW'(sel_idx);
        ptr    <= ptr_nxt;
      end
      if (capture_en) begin
        rsp_sum   <= dp_sum;
        rsp_cout  <= dp_cout;
        rsp_valid <= 1'b1;
`ifdef ADDSUB_ARB_OVF_EN
        rsp_ovf   <= ovf_calc;
`endif
      end
      if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Purpose: scoreboard bench for addsub_rr_arbiter with a behavioural CLA datapath model.
// Latency: expected grants/responses queued at issue; monitor checks on each gnt pulse and rsp handshake.
// Backpressure: rsp_ready is driven by the stimulus to stall the response port.

module tb_addsub_rr_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 12;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      dp_a;
  logic [W-1:0]      dp_b;
  logic              dp_sub;
  logic [W-1:0]      dp_sum;
  logic              dp_cout;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic              busy;
`ifdef ADDSUB_ARB_OVF_EN
  logic              rsp_ovf;
`endif

  always #5 clk = ~clk;

  // Datapath model: a + (sub ? ~b : b) + sub, carry-out from bit W.
  logic [W:0] dp_full;
  assign dp_full = {1'b0, dp_a} + {1'b0, (dp_sub ? ~dp_b : dp_b)} + {{W{1'b0}}, dp_sub};
  assign dp_sum  = dp_full[W-1:0];
  assign dp_cout = dp_full[W];

  addsub_rr_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .gnt       (gnt),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_sub    (dp_sub),
    .dp_sum    (dp_sum),
    .dp_cout   (dp_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
`ifdef ADDSUB_ARB_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .busy      (busy)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   sum;
    logic           cout;
    logic           ovf;
  } rsp_t;

  rsp_t            exp_q[$];
  logic [NREQ-1:0] gnt_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int gnt_count   = 0;
  int cyc         = 0;
  int last_gnt    = -1;
  bit chk_spacing = 1'b0;

  int fair_sum [4] = '{101, 198, 303, 396};
  int fair_cout[4] = '{0, 1, 0, 1};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic rsp_t mk(input int id, input int sum, input int cout, input int ovf);
    rsp_t r;
    r.id   = IDW'(id);
    r.sum  = W'(sum);
    r.cout = cout[0];
    r.ovf  = ovf[0];
    return r;
  endfunction

  // Monitor: grant pulses and response handshakes against the scoreboard.
  initial begin
    rsp_t            e;
    logic [NREQ-1:0] eg;
    forever begin
      @(negedge clk);
      if (gnt != '0) begin
        vectors++;
        if (gnt_q.size() == 0) begin
          miscompares++;
          $display("FAIL gnt: got %b, required no grant", gnt);
        end else begin
          eg = gnt_q.pop_front();
          if (gnt !== eg) begin
            miscompares++;
            $display("FAIL gnt: got %b, required %b", gnt, eg);
          end
        end
        if (chk_spacing && last_gnt >= 0) begin
          vectors++;
          if (cyc - last_gnt != 3) begin
            miscompares++;
            $display("FAIL gnt_spacing: got %0d cycles, required 3", cyc - last_gnt);
          end
        end
        last_gnt = cyc;
        gnt_count++;
      end
      if (rsp_valid && rsp_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rsp: got id=%0d sum=%h cout=%b, required no response", rsp_id, rsp_sum, rsp_cout);
        end else begin
          e = exp_q.pop_front();
          if (rsp_id !== e.id || rsp_sum !== e.sum || rsp_cout !== e.cout
`ifdef ADDSUB_ARB_OVF_EN
              || rsp_ovf !== e.ovf
`endif
             ) begin
            miscompares++;
            $display("FAIL rsp: got id=%0d sum=%h cout=%b, required id=%0d sum=%h cout=%b (ovf req %b)",
                     rsp_id, rsp_sum, rsp_cout, e.id, e.sum, e.cout, e.ovf);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"},       32'(gnt),       0);
    check({tag, "_dp_a"},      32'(dp_a),      0);
    check({tag, "_dp_b"},      32'(dp_b),      0);
    check({tag, "_dp_sub"},    32'(dp_sub),    0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_id"},    32'(rsp_id),    0);
    check({tag, "_rsp_sum"},   32'(rsp_sum),   0);
    check({tag, "_rsp_cout"},  32'(rsp_cout),  0);
    check({tag, "_busy"},      32'(busy),      0);
`ifdef ADDSUB_ARB_OVF_EN
    check({tag, "_rsp_ovf"},   32'(rsp_ovf),   0);
`endif
  endtask

  task automatic set_op(input int i, input int a, input int b, input int sub);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
    req_sub[i]      = sub[0];
  endtask

  task automatic wait_gnts(input int n);
    int start = gnt_count;
    int b = 0;
    while (gnt_count - start < n && b < 200) begin
      tick(1);
      b++;
    end
    if (gnt_count - start < n) begin
      vectors++;
      miscompares++;
      $display("FAIL gnt_timeout: got %0d grants, required %0d", gnt_count - start, n);
    end
  endtask

  task automatic wait_drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 200) begin
      tick(1);
      b++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL rsp_timeout: got %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
    tick(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic do_single(input int i, input int a, input int b, input int sub,
                           input int esum, input int ecout, input int eovf);
    set_op(i, a, b, sub);
    gnt_q.push_back(NREQ'(1 << i));
    exp_q.push_back(mk(i, esum, ecout, eovf));
    req = NREQ'(1 << i);
    wait_gnts(1);
    req = '0;
    wait_drain();
  endtask

  initial begin
    int b;
    rst       = 1'b1;
    req       = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;
    tick(3);
    check_zero("reset");
    rst = 1'b0;
    tick(1);

    // Single add with explicit grant/response latency.
    set_op(0, 10, 10, 0);
    gnt_q.push_back(4'b0001);
    exp_q.push_back(mk(0, 20, 0, 0));
    req = 4'b0001;
    tick(1);
    check("add_gnt_latency", 32'(gnt), 32'h1);
    tick(1);
    check("add_rsp_latency", 32'(rsp_valid), 32'h1);
    req = '0;
    wait_drain();

    // Subtract with and without borrow; single requester each time.
    do_single(2, 3, 5, 1, 12'hFFE, 0, 0);
    do_single(2, 30, 20, 1, 10, 1, 0);

    // Fairness: all requesting continuously.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 100 * (i + 1), i + 1, i % 2);
    for (int k = 0; k < 12; k++) begin
      gnt_q.push_back(NREQ'(1 << (k % 4)));
      exp_q.push_back(mk(k % 4, fair_sum[k % 4], fair_cout[k % 4], 0));
    end
    last_gnt    = -1;
    chk_spacing = 1'b1;
    req = 4'b1111;
    wait_gnts(12);
    req = '0;
    chk_spacing = 1'b0;
    wait_drain();

    // Backpressure: response stalled, no grants while waiting.
    do_reset();
    rsp_ready = 1'b0;
    gnt_q.push_back(4'b0001);
    gnt_q.push_back(4'b0010);
    exp_q.push_back(mk(0, fair_sum[0], fair_cout[0], 0));
    exp_q.push_back(mk(1, fair_sum[1], fair_cout[1], 0));
    req = 4'b1111;
    b = 0;
    while (!rsp_valid && b < 20) begin
      tick(1);
      b++;
    end
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'h1);
      check("bp_sum",   32'(rsp_sum),   32'(fair_sum[0]));
      check("bp_id",    32'(rsp_id),    32'h0);
      check("bp_nognt", 32'(gnt),       32'h0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    tick(1);
    check("bp_idle_busy",  32'(busy),      32'h0);
    check("bp_idle_valid", 32'(rsp_valid), 32'h0);
    wait_gnts(1);
    req = '0;
    wait_drain();

    // Reset during ISSUE: in-flight op discarded, ptr back to 0.
    gnt_q.push_back(4'b0100);
    req = 4'b0100;
    b = 0;
    while (gnt == '0 && b < 20) begin
      @(negedge clk);
      b++;
    end
    check("rst_mid_in_issue", 32'(gnt), 32'h4);
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    #1;
    check_zero("rst_mid");
    rst = 1'b0;
    gnt_q.push_back(4'b0010);
    gnt_q.push_back(4'b1000);
    exp_q.push_back(mk(1, fair_sum[1], fair_cout[1], 0));
    exp_q.push_back(mk(3, fair_sum[3], fair_cout[3], 0));
    req = 4'b1010;
    wait_gnts(2);
    req = '0;
    wait_drain();

    // Wrap-around / signed-overflow vectors.
    do_single(0, 12'h7FF, 12'h001, 0, 12'h800, 0, 1);
    do_single(0, 12'h800, 12'h001, 1, 12'h7FF, 1, 1);
    do_single(0, 12'hFFF, 12'h001, 0, 12'h000, 1, 0);

    check("gnt_queue_empty", 32'(gnt_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/addsub_rr_arbiter.md
Name: addsub_rr_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one 12-bit add/subtract datapath among NREQ requesters.
- Accepts one operation at a time and drives the datapath operand and control lines from registers.
- Captures the datapath sum and carry-out, then returns them with a requester ID on a valid/ready response port.
- Sits between the partial-product/accumulate control logic and the single CLA add/sub unit in the multiplier subsystem.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 12, operand/result width; must match the datapath width.
- IDW, 2, width of rsp_id; must be ≥ clog2(NREQ).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request; held high with operands stable until that requester's gnt.
- req_a  in  NREQ*W  flattened A operands; requester i occupies [i*W +: W].
- req_b  in  NREQ*W  flattened B operands, same packing.
- req_sub  in  NREQ  per-requester op select: 1 = a-b, 0 = a+b.
- gnt  out  NREQ  one-hot, one-cycle acceptance pulse.
- dp_a  out  W  datapath A operand (registered).
- dp_b  out  W  datapath B operand (registered, uninverted).
- dp_sub  out  1  datapath carry-in/subtract control (registered).
- dp_sum  in  W  datapath sum; combinational from dp_*, settled within one cycle.
- dp_cout  in  1  datapath carry-out; for subtract, 1 = no borrow.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_sum  out  W  captured result.
- rsp_cout  out  1  captured carry-out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, priority over all other logic, including mid-operation):
  - state=IDLE.
  - gnt, dp_a, dp_b, dp_sub, rsp_valid, rsp_id, rsp_sum, rsp_cout all 0.
  - Round-robin pointer ptr=0. Any in-flight operation is discarded.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first asserted req[i], searching i = ptr, ptr+1, ... modulo NREQ.
  - At the clock edge:
    - dp_a ← req_a[i]; dp_b ← req_b[i]; dp_sub ← req_sub[i]
    - rsp_id ← i
    - gnt ← one-hot(i)
    - ptr ← (i+1) mod NREQ
    - next state ISSUE.
- ISSUE (one cycle):
  - gnt is high for exactly this cycle; the requester may drop or change req and operands from the next cycle.
  - dp_* are stable. At the clock edge: rsp_sum ← dp_sum; rsp_cout ← dp_cout; rsp_valid ← 1; next state RESP; gnt ← 0.
- RESP:
  - rsp_valid, rsp_id, rsp_sum and rsp_cout are held stable while rsp_ready=0.
  - On rsp_valid & rsp_ready at a clock edge: rsp_valid ← 0, next state IDLE.
  - dp_* retain their last values; they are not cleared.
- Timing:
  - req sampled in IDLE cycle t → gnt in cycle t+1 → rsp_valid from cycle t+2.
  - Best-case throughput is one operation per 3 cycles (rsp_ready tied high).
- Arithmetic:
  - The block never inverts B; the datapath applies ~b and carry-in on dp_sub.
  - Results are W-bit modulo 2^W with wrap-around and no saturation.
- Boundary conditions:
  - req is ignored outside IDLE; requesters keep waiting.
  - A requester dropping req before its gnt loses its place with no side effects.
  - req still high after gnt is treated as a new request; round-robin prevents starvation.
  - All NREQ requesting continuously → grant order 0,1,2,3,0,...
  - A single requester is granted every 3 cycles regardless of ptr.
  - req bits at or above NREQ do not exist; IDW upper bits of rsp_id are 0.

Optional Feature:
- Macro: ADDSUB_ARB_OVF_EN.
- Defined: adds output port rsp_ovf (1 bit), captured in ISSUE alongside rsp_sum and reset to 0. It is the two's-complement signed-overflow flag:
  - add: ovf = (a[W-1]==b[W-1]) & (sum[W-1]!=a[W-1])
  - sub: ovf = (a[W-1]!=b[W-1]) & (sum[W-1]!=a[W-1])
  - a, b are dp_a, dp_b; sum is dp_sum.
- Undefined: port absent, no overflow logic; all other behaviour identical.

Test Plan:
- Single add: req=0001, a0=10, b0=10, sub0=0, rsp_ready=1 → gnt=0001 one cycle later; rsp_valid next cycle with rsp_id=0, rsp_sum=20, rsp_cout=0.
- Subtract with borrow: req=0100, a2=3, b2=5, sub2=1 → rsp_id=2, rsp_sum=0xFFE, rsp_cout=0. Then a2=30, b2=20 → rsp_sum=10, rsp_cout=1.
- Fairness: req=1111 held, rsp_ready=1 for 12 ops → gnt sequence 0001,0010,0100,1000 repeated, one grant every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_sum and rsp_id unchanged, no new gnt despite req=1111. Raise rsp_ready → one transfer, IDLE next cycle.
- Reset mid-op: assert rst during ISSUE → next cycle all outputs 0, busy=0, ptr=0. Then req=1010 → gnt=0010 first.
- Overflow (with ADDSUB_ARB_OVF_EN): add 0x7FF+0x001 → rsp_sum=0x800, rsp_ovf=1. Sub 0x800-0x001 → rsp_sum=0x7FF, rsp_ovf=1. Add 0xFFF+0x001 → rsp_sum=0x000, rsp_cout=1, rsp_ovf=0.
